gps_corr_dump: RTL and testbench
================================

GPS_CORR_DUMP -- requirements
Module: gps_corr_dump

Interface
REQ-001 SHALL provide parameters, one per line:
- ACC_W, 32, accumulator and dump register width
- CNT_W, 16, epoch counter width
REQ-002 SHALL provide the following ports, one per line (name  direction  width  meaning):
- mclk  in  1  correlator sample clock; the only clock
- mclr  in  1  reset, asynchronous, active-low
- sample_valid  in  1  arm inputs valid this cycle
- ie, qe, ip, qp, il, ql  in  3 each  signed two's-complement correlator products, range -3..+3
- epoch  in  1  single-cycle pulse marking the code-epoch boundary
- dump_clr  in  1  single-cycle pulse from the register side acknowledging a dump
- die, dqe, dip, dqp, dil, dql  out  ACC_W each  latched integrate-and-dump results
- dump_ready  out  1  new dump is available (status bit 0)
- dump_overrun  out  1  sticky flag: a dump was overwritten before it was acknowledged
- epoch_count  out  CNT_W  number of epochs seen since reset
REQ-003 SHALL use one clock, mclk; reset SHALL be asynchronous and active-low, on port mclr.

Function
REQ-004 SHALL keep six internal accumulators, one per arm, each ACC_W bits signed.
REQ-005 When sample_valid=1 and epoch=0, each accumulator SHALL add the sign-extended value of its arm input on the rising edge of mclk.
REQ-006 Accumulation SHALL wrap modulo 2^ACC_W, with no saturation and no overflow flag.
REQ-007 When sample_valid=0 and epoch=0, the accumulators SHALL hold their values.
REQ-008 On an epoch cycle, each dump register SHALL load its accumulator value plus the current-cycle sample if sample_valid=1, and each accumulator SHALL load 0.
REQ-009 Dump registers SHALL be updated only on epoch cycles.
REQ-010 Latency SHALL be 1 cycle: for epoch at edge n, the new dump values and dump_ready=1 SHALL be visible after edge n.
REQ-011 SHALL implement a 3-state FSM driving dump_ready and dump_overrun:
- EMPTY: dump_ready=0, dump_overrun=0
- FULL: dump_ready=1, dump_overrun=0
- OVERRUN: dump_ready=1, dump_overrun=1
REQ-012 EMPTY transitions: epoch -> FULL; dump_clr alone -> EMPTY (ignored).
REQ-013 FULL transitions: epoch without dump_clr -> OVERRUN; dump_clr without epoch -> EMPTY; epoch with dump_clr -> FULL (new data wins, old dump counts as acknowledged).
REQ-014 OVERRUN transitions: epoch without dump_clr -> OVERRUN; dump_clr without epoch -> EMPTY; epoch with dump_clr -> FULL.
REQ-015 dump_clr SHALL NOT modify the dump registers or the accumulators.
REQ-016 epoch_count SHALL increment by 1 on every epoch and wrap from 2^CNT_W-1 to 0.
REQ-017 Consecutive epochs (epoch high on adjacent cycles) SHALL each cause a full dump; the second dump SHALL contain only the second cycle's sample, or 0.
REQ-018 epoch and sample_valid SHALL be treated as independent; an epoch with sample_valid=0 SHALL dump the accumulator value unchanged.

Reset
REQ-019 While mclr=0, all accumulators, dump registers and epoch_count SHALL be 0, dump_ready=0, dump_overrun=0, and the FSM SHALL be in EMPTY; this SHALL take effect immediately, independent of mclk.
REQ-020 A reset asserted mid-integration SHALL discard partial sums; after mclr deasserts, the first dump SHALL contain only samples taken after release.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- V1: Drive ip=+1 and qp=-1 with sample_valid=1 for 1000 cycles, epoch on the 1000th cycle -> next cycle dip=1000, dqp=0xFFFFFC18, dump_ready=1, epoch_count=1.
- V2: After V1, pulse dump_clr -> dump_ready=0; dip unchanged at 1000.
- V3: Issue two epochs 10 cycles apart, no dump_clr, ip=+3 -> dump_overrun=1 and dip=30; then pulse dump_clr -> both flags 0.
- V4: Issue epoch and dump_clr in the same cycle while in FULL -> dump_ready=1, dump_overrun=0, new data latched.
- V5: Force the accumulator to 0x7FFFFFFE, apply ip=+3 then epoch -> dip=0x80000001 (wrap).
- V6: Assert mclr low mid-integration, asynchronous to mclk -> all outputs 0 immediately; after release, 5 samples of il=-2 plus epoch -> dil=0xFFFFFFF6, epoch_count=1.

Source files
------------

// File: rtl/gps_corr_dump.sv
// Six-arm GPS correlator integrate-and-dump with epoch-triggered latching,
// dump handshake status (EMPTY/FULL/OVERRUN) and an epoch counter.
module gps_corr_dump #(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             mclk,
   input  logic             mclr,
   input  logic             sample_valid,
   input  logic [2:0]       ie,
   input  logic [2:0]       qe,
   input  logic [2:0]       ip,
   input  logic [2:0]       qp,
   input  logic [2:0]       il,
   input  logic [2:0]       ql,
   input  logic             epoch,
   input  logic             dump_clr,
   output logic [ACC_W-1:0] die,
   output logic [ACC_W-1:0] dqe,
   output logic [ACC_W-1:0] dip,
   output logic [ACC_W-1:0] dqp,
   output logic [ACC_W-1:0] dil,
   output logic [ACC_W-1:0] dql,
   output logic             dump_ready,
   output logic             dump_overrun,
   output logic [CNT_W-1:0] epoch_count
);

   typedef enum logic [1:0] {StEmpty, StFull, StOverrun} state_e;

   state_e           state_q, state_d;
   logic [2:0]       arm    [6];
   logic [ACC_W-1:0] ext    [6];
   logic [ACC_W-1:0] acc_q  [6];
   logic [ACC_W-1:0] acc_d  [6];
   logic [ACC_W-1:0] dump_q [6];
   logic [ACC_W-1:0] dump_d [6];
   logic [CNT_W-1:0] count_q, count_d;

   assign arm[0] = ie;
   assign arm[1] = qe;
   assign arm[2] = ip;
   assign arm[3] = qp;
   assign arm[4] = il;
   assign arm[5] = ql;

   // The epoch-cycle sample belongs to the closing integration, not the next one.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         ext[i]    = sample_valid ? {{(ACC_W-3){arm[i][2]}}, arm[i]} : '0;
         acc_d[i]  = acc_q[i];
         dump_d[i] = dump_q[i];
         if (epoch) begin
            dump_d[i] = acc_q[i] + ext[i];
            acc_d[i]  = '0;
         end else begin
            acc_d[i]  = acc_q[i] + ext[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StEmpty: begin
            if (epoch) state_d = StFull;
         end
         StFull, StOverrun: begin
            if (epoch)         state_d = dump_clr ? StFull : StOverrun;
            else if (dump_clr) state_d = StEmpty;
         end
         default: state_d = StEmpty;
      endcase
   end

   assign count_d = epoch ? count_q + 1'b1 : count_q;

   always_ff @(posedge mclk or negedge mclr) begin
      if (!mclr) begin
         state_q <= StEmpty;
         count_q <= '0;
         for (int i = 0; i < 6; i++) begin
            acc_q[i]  <= '0;
            dump_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         for (int i = 0; i < 6; i++) begin
            acc_q[i]  <= acc_d[i];
            dump_q[i] <= dump_d[i];
         end
      end
   end

   assign die          = dump_q[0];
   assign dqe          = dump_q[1];
   assign dip          = dump_q[2];
   assign dqp          = dump_q[3];
   assign dil          = dump_q[4];
   assign dql          = dump_q[5];
   assign dump_ready   = (state_q != StEmpty);
   assign dump_overrun = (state_q == StOverrun);
   assign epoch_count  = count_q;

endmodule

// File: tb/tb_gps_corr_dump.sv
// Scoreboard bench for gps_corr_dump: directed scenarios plus random traffic
// against an arithmetic reference model; a monitor checks every clocked cycle.
module tb_gps_corr_dump;

   localparam int ACC_W = 32;
   localparam int CNT_W = 8;

   logic             mclk, mclr, sample_valid, epoch, dump_clr;
   logic [2:0]       ie, qe, ip, qp, il, ql;
   logic [ACC_W-1:0] die, dqe, dip, dqp, dil, dql;
   logic             dump_ready, dump_overrun;
   logic [CNT_W-1:0] epoch_count;
   logic [ACC_W-1:0] dout [6];

   gps_corr_dump #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .mclk(mclk), .mclr(mclr), .sample_valid(sample_valid),
      .ie(ie), .qe(qe), .ip(ip), .qp(qp), .il(il), .ql(ql),
      .epoch(epoch), .dump_clr(dump_clr),
      .die(die), .dqe(dqe), .dip(dip), .dqp(dqp), .dil(dil), .dql(dql),
      .dump_ready(dump_ready), .dump_overrun(dump_overrun), .epoch_count(epoch_count)
   );

   assign dout[0] = die;
   assign dout[1] = dqe;
   assign dout[2] = dip;
   assign dout[3] = dqp;
   assign dout[4] = dil;
   assign dout[5] = dql;

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   typedef struct packed {
      logic [5:0][ACC_W-1:0] d;
      logic                  rdy;
      logic                  ovr;
      logic [CNT_W-1:0]      cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: integer sums per arm, status as ready/overrun flags
   logic [ACC_W-1:0] m_acc  [6];
   logic [ACC_W-1:0] m_dump [6];
   logic             m_rdy, m_ovr;
   logic [CNT_W-1:0] m_cnt;

   task automatic check(input string name, input logic [ACC_W-1:0] act,
                        input logic [ACC_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) begin
         m_acc[i]  = '0;
         m_dump[i] = '0;
      end
      m_rdy = 1'b0;
      m_ovr = 1'b0;
      m_cnt = '0;
   endtask

   task automatic step(input bit sv, input int a[6], input bit ep, input bit clr);
      exp_t e;
      @(negedge mclk);
      sample_valid = sv;
      ie = 3'(a[0]); qe = 3'(a[1]); ip = 3'(a[2]);
      qp = 3'(a[3]); il = 3'(a[4]); ql = 3'(a[5]);
      epoch    = ep;
      dump_clr = clr;
      if (ep) begin
         for (int i = 0; i < 6; i++) begin
            m_dump[i] = m_acc[i] + (sv ? ACC_W'(a[i]) : '0);
            m_acc[i]  = '0;
         end
         m_ovr = m_rdy && !clr;
         m_rdy = 1'b1;
         m_cnt = m_cnt + 1'b1;
      end else begin
         if (clr) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
         end
         if (sv) for (int i = 0; i < 6; i++) m_acc[i] = m_acc[i] + ACC_W'(a[i]);
      end
      for (int i = 0; i < 6; i++) e.d[i] = m_dump[i];
      e.rdy = m_rdy;
      e.ovr = m_ovr;
      e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic settle();
      @(posedge mclk);
      #2;
   endtask

   // Monitor: one expectation per driven cycle, checked just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge mclk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 6; i++) check($sformatf("dump[%0d]", i), dout[i], e.d[i]);
            check("dump_ready", ACC_W'(dump_ready), ACC_W'(e.rdy));
            check("dump_overrun", ACC_W'(dump_overrun), ACC_W'(e.ovr));
            check("epoch_count", ACC_W'(epoch_count), ACC_W'(e.cnt));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int z[6];
      int a[6];
      z = '{0, 0, 0, 0, 0, 0};
      sample_valid = 1'b0; epoch = 1'b0; dump_clr = 1'b0;
      ie = '0; qe = '0; ip = '0; qp = '0; il = '0; ql = '0;
      model_reset();
      mclr = 1'b1;
      #3 mclr = 1'b0;
      #1;
      check("reset dip", dip, '0);
      check("reset ready", ACC_W'(dump_ready), '0);
      check("reset count", ACC_W'(epoch_count), '0);
      @(negedge mclk);
      mclr = 1'b1;

      // V1: ip=+1, qp=-1 for 1000 cycles, epoch on the last
      a = '{0, 0, 1, -1, 0, 0};
      for (int n = 0; n < 999; n++) step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, a, 1'b1, 1'b0);
      settle();
      check("V1 dip", dip, 32'd1000);
      check("V1 dqp", dqp, 32'hFFFFFC18);
      check("V1 ready", ACC_W'(dump_ready), 32'd1);
      check("V1 count", ACC_W'(epoch_count), 32'd1);

      // V2: acknowledge
      step(1'b0, z, 1'b0, 1'b1);
      settle();
      check("V2 ready", ACC_W'(dump_ready), 32'd0);
      check("V2 dip", dip, 32'd1000);

      // V3: two epochs 10 cycles apart without acknowledge
      a = '{0, 0, 3, 0, 0, 0};
      step(1'b0, z, 1'b1, 1'b0);
      for (int n = 0; n < 9; n++) step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, a, 1'b1, 1'b0);
      settle();
      check("V3 overrun", ACC_W'(dump_overrun), 32'd1);
      check("V3 dip", dip, 32'd30);
      step(1'b0, z, 1'b0, 1'b1);
      settle();
      check("V3 clr ready", ACC_W'(dump_ready), 32'd0);
      check("V3 clr overrun", ACC_W'(dump_overrun), 32'd0);

      // V4: epoch and dump_clr together while FULL
      a = '{0, 0, 2, 0, 0, 0};
      step(1'b0, z, 1'b1, 1'b0);
      for (int n = 0; n < 4; n++) step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, a, 1'b1, 1'b1);
      settle();
      check("V4 ready", ACC_W'(dump_ready), 32'd1);
      check("V4 overrun", ACC_W'(dump_overrun), 32'd0);
      check("V4 dip", dip, 32'd10);

      // V5: preload the ip accumulator near the positive limit
      step(1'b0, z, 1'b0, 1'b0);
      settle();
      dut.acc_q[2] = 32'h7FFFFFFE;
      m_acc[2] = 32'h7FFFFFFE;
      a = '{0, 0, 3, 0, 0, 0};
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b0, z, 1'b1, 1'b0);
      settle();
      check("V5 dip wrap", dip, 32'h80000001);

      // V6: asynchronous reset mid-integration
      a = '{1, -2, 3, -3, 2, -1};
      for (int n = 0; n < 7; n++) step(1'b1, a, 1'b0, 1'b0);
      settle();
      #2 mclr = 1'b0;
      #1;
      check("V6 dil async", dil, '0);
      check("V6 dip async", dip, '0);
      check("V6 ready async", ACC_W'(dump_ready), '0);
      check("V6 count async", ACC_W'(epoch_count), '0);
      model_reset();
      exp_q.delete();
      repeat (2) @(negedge mclk);
      sample_valid = 1'b0; epoch = 1'b0; dump_clr = 1'b0;
      mclr = 1'b1;
      a = '{0, 0, 0, 0, -2, 0};
      for (int n = 0; n < 4; n++) step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, a, 1'b1, 1'b0);
      settle();
      check("V6 dil", dil, 32'hFFFFFFF6);
      check("V6 count", ACC_W'(epoch_count), 32'd1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 6; i++) a[i] = int'($urandom_range(6)) - 3;
         step($urandom_range(3) != 0, a, $urandom_range(19) == 0, $urandom_range(7) == 0);
      end
      // Back-to-back epochs, long enough to wrap the epoch counter
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 6; i++) a[i] = int'($urandom_range(6)) - 3;
         step($urandom_range(1) != 0, a, 1'b1, $urandom_range(3) == 0);
      end
      step(1'b0, z, 1'b0, 1'b0);
      settle();
      check("scoreboard drained", ACC_W'(exp_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
